// File: rtl/qm_hazard_pkg.sv
// qm_hazard_pkg: shared types and constants for the decode-stage issue
// controller (qm_hazard) and its register scoreboard (qm_scoreboard).
package qm_hazard_pkg;

  localparam int REG_COUNT = 32;   // architectural registers, r0 hard-wired
  localparam int CNT_W     = 2;    // pending-write counter width per register
  localparam int STALL_W   = 32;   // stall performance counter width
  localparam int FCNT_W    = 3;    // flush down-counter width (FLUSH_CYCLES <= 7)

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [4:0]       reg_idx_t;

  localparam cnt_t CNT_MAX = cnt_t'(3);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/qm_scoreboard.sv
// qm_scoreboard: one 2-bit pending-write counter per register r1..r31.
//   clk, rst          : clock, synchronous active-high reset
//   rs_idx / rs_cnt   : combinational read port A
//   rt_idx / rt_cnt   : combinational read port B
//   wa_idx / wa_full  : destination full check (count == CNT_MAX)
//   inc_en / inc_idx  : +1 at the clock edge (instruction issued)
//   dec_en / dec_idx  : -1 at the clock edge (register written back)
// r0 never holds a count: reads return 0 and updates to it are dropped.
import qm_hazard_pkg::*;

module qm_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_idx,
  input  logic [4:0] rt_idx,
  input  logic [4:0] wa_idx,
  input  logic       inc_en,
  input  logic [4:0] inc_idx,
  input  logic       dec_en,
  input  logic [4:0] dec_idx,
  output logic [1:0] rs_cnt,
  output logic [1:0] rt_cnt,
  output logic       wa_full
);

  cnt_t                 cnt_q [1:REG_COUNT-1];
  logic [REG_COUNT-1:1] inc_hit;
  logic [REG_COUNT-1:1] dec_hit;
  cnt_t                 wa_cnt;
  cnt_t                 dec_cnt;

  assign rs_cnt  = (rs_idx  == '0) ? '0 : cnt_q[rs_idx];
  assign rt_cnt  = (rt_idx  == '0) ? '0 : cnt_q[rt_idx];
  assign wa_cnt  = (wa_idx  == '0) ? '0 : cnt_q[wa_idx];
  assign dec_cnt = (dec_idx == '0) ? '0 : cnt_q[dec_idx];
  assign wa_full = (wa_cnt == CNT_MAX);

  // Decoding starts at 1, so updates addressed to r0 never match an entry.
  // NOTE: every output of an always_comb gets a default first; otherwise any
  // path that skips an assignment infers a latch.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      inc_hit[i] = inc_en && (inc_idx == 5'(i));
      dec_hit[i] = dec_en && (dec_idx == 5'(i));
    end
  end

  // NOTE: this array is state, not storage: a stale count left over from
  // before reset would stall its register forever, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        // A simultaneous issue and retire on one register cancel out.
        // The issue side never sees a full counter: a full destination is a
        // hazard and blocks issue, so +1 cannot wrap.
        if (inc_hit[i] && !dec_hit[i])
          cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_hit[i] && !inc_hit[i] && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // A write-back to a register with nothing in flight is a protocol error;
  // the counter saturates at 0 but the event is flagged.
  underflow_a: assert property (@(posedge clk) disable iff (rst)
    !(dec_en && dec_idx != '0 && !(inc_en && inc_idx == dec_idx) && dec_cnt == '0));

endmodule

// File: rtl/qm_hazard.sv
// qm_hazard: in-order issue controller beside the decode stage.
//   sys_clk, sys_rst           : clock, synchronous active-high reset
//   dec_*                      : instruction currently in decode
//   wb_WE, wb_WA               : regfile write port (retires pending writes)
//   ex_BranchTaken             : taken branch resolved in execute
//   o_Issue / o_Stall / o_Flush: combinational pipeline controls
//   o_StallCount               : saturating count of stall cycles
// Parameter FLUSH_CYCLES (1..7): decode squash length after a taken branch.
// Build option QM_HAZARD_WB_BYPASS_EN: a source whose only pending write is
// retiring this cycle is read through the regfile's write-before-read path
// and does not stall.
import qm_hazard_pkg::*;

module qm_hazard #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dec_Valid,
  input  logic [4:0]  dec_RS,
  input  logic [4:0]  dec_RT,
  input  logic        dec_UsesRS,
  input  logic        dec_UsesRT,
  input  logic        dec_WE,
  input  logic [4:0]  dec_WA,
  input  logic        wb_WE,
  input  logic [4:0]  wb_WA,
  input  logic        ex_BranchTaken,
  output logic        o_Issue,
  output logic        o_Stall,
  output logic        o_Flush,
  output logic [31:0] o_StallCount
);

  state_t              state_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [STALL_W-1:0]  stall_cnt_q;
  cnt_t                rs_cnt, rt_cnt;
  logic                wa_full;
  logic                rs_haz, rt_haz, hazard;

  qm_scoreboard u_scoreboard (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .rs_idx  (dec_RS),
    .rt_idx  (dec_RT),
    .wa_idx  (dec_WA),
    .inc_en  (o_Issue && dec_WE),
    .inc_idx (dec_WA),
    .dec_en  (wb_WE),
    .dec_idx (wb_WA),
    .rs_cnt  (rs_cnt),
    .rt_cnt  (rt_cnt),
    .wa_full (wa_full)
  );

`ifdef QM_HAZARD_WB_BYPASS_EN
  // The last outstanding write landing this cycle is visible to the read.
  assign rs_haz = dec_UsesRS && rs_cnt != '0 &&
                  !(rs_cnt == cnt_t'(1) && wb_WE && wb_WA == dec_RS);
  assign rt_haz = dec_UsesRT && rt_cnt != '0 &&
                  !(rt_cnt == cnt_t'(1) && wb_WE && wb_WA == dec_RT);
`else
  assign rs_haz = dec_UsesRS && rs_cnt != '0;
  assign rt_haz = dec_UsesRT && rt_cnt != '0;
`endif

  // r0 reads as count 0, so only the destination needs an explicit r0 guard
  // (wa_full is already false for r0; the guard documents intent).
  assign hazard = dec_Valid && (rs_haz || rt_haz || (dec_WE && dec_WA != '0 && wa_full));

  // Flush owns the cycle: the squashed instruction neither issues nor stalls.
  always_comb begin
    o_Issue = 1'b0;
    o_Stall = 1'b0;
    o_Flush = 1'b0;
    if (ex_BranchTaken || state_q == ST_FLUSH) begin
      o_Flush = 1'b1;
    end else begin
      o_Issue = dec_Valid && !hazard;
      o_Stall = dec_Valid && hazard;
    end
  end

  // The branch cycle is the first flush cycle; FLUSH covers the remaining
  // FLUSH_CYCLES-1, with fcnt counting down to 0 on the last of them.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else if (ex_BranchTaken) begin
      if (FLUSH_CYCLES > 1) begin
        state_q <= ST_FLUSH;
        fcnt_q  <= FCNT_W'(FLUSH_CYCLES - 2);
      end else begin
        state_q <= ST_RUN;
        fcnt_q  <= '0;
      end
    end else if (state_q == ST_FLUSH) begin
      if (fcnt_q == '0) state_q <= ST_RUN;
      else              fcnt_q  <= fcnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      stall_cnt_q <= '0;
    else if (o_Stall && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign o_StallCount = stall_cnt_q;

endmodule

// File: tb/tb_qm_hazard.sv
// tb_qm_hazard: directed stimulus for qm_hazard (FLUSH_CYCLES=2) with a
// per-cycle reference model (pending-write counts per register, remaining
// flush cycles, stall count) plus literal expectations at key points.
module tb_qm_hazard;

`ifdef QM_HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FC = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dec_Valid, dec_UsesRS, dec_UsesRT, dec_WE, wb_WE, ex_BranchTaken;
  logic [4:0]  dec_RS, dec_RT, dec_WA, wb_WA;
  logic        o_Issue, o_Stall, o_Flush;
  logic [31:0] o_StallCount;

  int n_checks = 0;
  int n_err    = 0;
  bit preset   = 1'b0;

  // reference model state
  int          m_cnt [32];
  int          m_flush_left = 0;
  logic [31:0] m_stall = '0;

  qm_hazard #(.FLUSH_CYCLES(FC)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .dec_Valid      (dec_Valid),
    .dec_RS         (dec_RS),
    .dec_RT         (dec_RT),
    .dec_UsesRS     (dec_UsesRS),
    .dec_UsesRT     (dec_UsesRT),
    .dec_WE         (dec_WE),
    .dec_WA         (dec_WA),
    .wb_WE          (wb_WE),
    .wb_WA          (wb_WA),
    .ex_BranchTaken (ex_BranchTaken),
    .o_Issue        (o_Issue),
    .o_Stall        (o_Stall),
    .o_Flush        (o_Flush),
    .o_StallCount   (o_StallCount)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_blocked(input logic used, input logic [4:0] r);
    if (!used || r == 5'd0 || m_cnt[r] == 0) return 1'b0;
    if (BYP && m_cnt[r] == 1 && wb_WE && wb_WA == r) return 1'b0;
    return 1'b1;
  endfunction

  // Compare on the falling edge (inputs stable since posedge+1), then advance
  // the model to the state the coming rising edge will produce.
  always @(negedge sys_clk) begin
    bit exp_flush, haz, exp_issue, exp_stall;
    if (preset) m_stall = 32'hFFFF_FFFE;
    if (sys_rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_flush_left = 0;
      m_stall      = '0;
    end else begin
      exp_flush = ex_BranchTaken || (m_flush_left > 0);
      haz = dec_Valid && (src_blocked(dec_UsesRS, dec_RS) || src_blocked(dec_UsesRT, dec_RT) ||
                          (dec_WE && dec_WA != 5'd0 && m_cnt[dec_WA] >= 3));
      exp_issue = !exp_flush && dec_Valid && !haz;
      exp_stall = !exp_flush && dec_Valid && haz;
      check("model_issue", {31'd0, o_Issue}, {31'd0, exp_issue});
      check("model_stall", {31'd0, o_Stall}, {31'd0, exp_stall});
      check("model_flush", {31'd0, o_Flush}, {31'd0, exp_flush});
      check("model_stall_count", o_StallCount, m_stall);
      if (ex_BranchTaken)        m_flush_left = FC - 1;
      else if (m_flush_left > 0) m_flush_left--;
      if (exp_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (exp_issue && dec_WE && dec_WA != 5'd0) m_cnt[dec_WA]++;
      if (wb_WE && wb_WA != 5'd0 && m_cnt[wb_WA] > 0) m_cnt[wb_WA]--;
    end
  end

  // One decode cycle: drive just after the rising edge, let logic settle.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic we, input logic [4:0] wa,
                     input logic wbwe, input logic [4:0] wbwa, input logic br);
    @(posedge sys_clk);
    #1;
    preset     = 1'b0;
    dec_Valid  = v;   dec_RS = rs; dec_UsesRS = urs; dec_RT = rt; dec_UsesRT = urt;
    dec_WE     = we;  dec_WA = wa;
    wb_WE      = wbwe; wb_WA = wbwa;
    ex_BranchTaken = br;
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string name, input logic iss, input logic stl, input logic fl);
    check({name, "_issue"}, {31'd0, o_Issue}, {31'd0, iss});
    check({name, "_stall"}, {31'd0, o_Stall}, {31'd0, stl});
    check({name, "_flush"}, {31'd0, o_Flush}, {31'd0, fl});
  endtask

  initial begin
    sys_rst = 1'b1;
    dec_Valid = 0; dec_RS = 0; dec_RT = 0; dec_UsesRS = 0; dec_UsesRT = 0;
    dec_WE = 0; dec_WA = 0; wb_WE = 0; wb_WA = 0; ex_BranchTaken = 0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    #2;
    lit("reset", 0, 0, 0);
    check("reset_stall_count", o_StallCount, 32'd0);

    // RAW on r3: add r3 then sub r4 <- r3
    cyc(1, 1, 1, 2, 1, 1, 5'd3, 0, 0, 0);  lit("add_r3", 1, 0, 0);
    cyc(1, 3, 1, 0, 0, 1, 5'd4, 0, 0, 0);  lit("sub_wait1", 0, 1, 0);
    cyc(1, 3, 1, 0, 0, 1, 5'd4, 0, 0, 0);  lit("sub_wait2", 0, 1, 0);
    cyc(1, 3, 1, 0, 0, 1, 5'd4, 1, 5'd3, 0);
    lit("sub_wb_cycle", BYP, !BYP, 0);
    if (!BYP) begin
      cyc(1, 3, 1, 0, 0, 1, 5'd4, 0, 0, 0);  lit("sub_after_wb", 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
    check("raw_stall_count", o_StallCount, BYP ? 32'd2 : 32'd3);

    // r0 is never pending
    cyc(1, 1, 1, 0, 0, 1, 5'd0, 0, 0, 0);  lit("write_r0", 1, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);     lit("read_r0", 1, 0, 0);

    // counter full on r5
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0); lit("fill_r5", 1, 0, 0);
    end
    cyc(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);  lit("r5_full", 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0); lit("r5_full_wb", 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);  lit("r5_after_wb", 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0);

    // taken branch, FLUSH_CYCLES=2; the squashed write to r6 must not count
    cyc(1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 1);  lit("branch", 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 0);  lit("flush2", 0, 0, 1);
    cyc(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);     lit("post_flush_read_r6", 1, 0, 0);

    // branch during flush restarts the squash window
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);     lit("br_a", 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);     lit("br_b", 0, 0, 1);
    idle();                                lit("br_tail", 0, 0, 1);
    idle();                                lit("br_done", 0, 0, 0);

    // reset mid-flush with r7 pending
    cyc(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);  lit("write_r7", 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);     lit("r7_branch", 0, 0, 1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    ex_BranchTaken = 0;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    #2;
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);     lit("post_reset_r7", 1, 0, 0);
    check("post_reset_stall_count", o_StallCount, 32'd0);

    // stall counter saturation
    cyc(1, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);  lit("write_r8", 1, 0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    preset = 1'b1;
    repeat (3) begin
      cyc(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);   lit("sat_stall", 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0);
    check("saturated_stall_count", o_StallCount, 32'hFFFF_FFFF);
    idle();
    @(posedge sys_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
